// File: rtl/dmem_responder_if.sv
// Load/store request/response bus between the core (master) and the data memory (slave).
// Handshake: a transfer happens on any rising edge where VALID and READY are both 1;
// a source holds VALID and its payload stable until that edge, and READY never waits on VALID.
interface dmem_responder_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WE;
  logic [2:0]  REQ_FUNC3;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;

  modport master (
    output REQ_VALID, REQ_WE, REQ_FUNC3, REQ_ADDR, REQ_WDATA, RSP_READY,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR
  );

  modport slave (
    input  REQ_VALID, REQ_WE, REQ_FUNC3, REQ_ADDR, REQ_WDATA, RSP_READY,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle RV32I data-memory target: one request, WAIT_CYCLES of busy time, one response.
// Optional macro DMEM_MISALIGN_ERR_EN flags misaligned/undefined accesses via RSP_ERR.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  dmem_responder_if.slave  bus,
  output logic [1:0]       dbg_state
);

  localparam int AW       = $clog2(DEPTH_WORDS);
  localparam int CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int CNT_INIT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state, state_next;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [CW-1:0] cnt;

  logic          we_q;
  logic [2:0]    f3_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;

  logic          rsp_valid_q;
  logic          rsp_err_q;
  logic [31:0]   rsp_rdata_q;

  logic          accept;
  logic          access;

  logic          we_s;
  logic [2:0]    f3_s;
  logic [AW+1:0] addr_s;
  logic [31:0]   wdata_s;

  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_data;
  logic [31:0]   wr_lanes;
  logic [3:0]    be;
  logic          acc_err;

  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    access     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.REQ_VALID) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            access     = 1'b1;
            state_next = S_RESP;
          end else begin
            state_next = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (cnt == '0) begin
          access     = 1'b1;
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_valid_q && bus.RSP_READY) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // With zero wait the access happens on the accept edge, so use the live request fields.
  always_comb begin
    if (state == S_IDLE) begin
      we_s    = bus.REQ_WE;
      f3_s    = bus.REQ_FUNC3;
      addr_s  = bus.REQ_ADDR[AW+1:0];
      wdata_s = bus.REQ_WDATA;
    end else begin
      we_s    = we_q;
      f3_s    = f3_q;
      addr_s  = addr_q;
      wdata_s = wdata_q;
    end
  end

  assign word_idx = addr_s[AW+1:2];
  assign rd_word  = mem[word_idx];
  assign rd_byte  = rd_word[{addr_s[1:0], 3'b000} +: 8];
  assign rd_half  = addr_s[1] ? rd_word[31:16] : rd_word[15:0];

`ifdef DMEM_MISALIGN_ERR_EN
  logic misalign;
  logic f3_undef;
  always_comb begin
    misalign = ((f3_s[1:0] == 2'b01) && addr_s[0]) ||
               ((f3_s[1:0] == 2'b10) && (addr_s[1:0] != 2'b00));
    f3_undef = we_s ? (f3_s[2] || (f3_s[1:0] == 2'b11))
                    : ((f3_s == 3'b011) || (f3_s[2:1] == 2'b11));
    acc_err  = misalign || f3_undef;
  end
`else
  assign acc_err = 1'b0;
`endif

  always_comb begin
    load_data = 32'h0;
    case (f3_s)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b010:  load_data = rd_word;
      3'b100:  load_data = {24'h0, rd_byte};
      3'b101:  load_data = {16'h0, rd_half};
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    be       = 4'b0000;
    wr_lanes = wdata_s;
    case (f3_s)
      3'b000: begin
        be       = 4'b0001 << addr_s[1:0];
        wr_lanes = {4{wdata_s[7:0]}};
      end
      3'b001: begin
        be       = addr_s[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{wdata_s[15:0]}};
      end
      3'b010:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    if (acc_err) be = 4'b0000;
  end

  // Storage is deliberately not reset; a write aborted by reset must not land.
  always_ff @(posedge CLK) begin
    if (access && we_s && !RESET) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt         <= '0;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= bus.REQ_WE;
        f3_q    <= bus.REQ_FUNC3;
        addr_q  <= bus.REQ_ADDR[AW+1:0];
        wdata_q <= bus.REQ_WDATA;
        cnt     <= CW'(CNT_INIT);
      end else if ((state == S_BUSY) && (cnt != '0)) begin
        cnt <= cnt - CW'(1);
      end
      if (access) begin
        rsp_rdata_q <= (we_s || acc_err) ? 32'h0 : load_data;
        rsp_err_q   <= acc_err;
      end
      // Response valid is registered, so it rises one edge after RESP is entered.
      rsp_valid_q <= (state == S_RESP) && !(rsp_valid_q && bus.RSP_READY);
    end
  end

  assign bus.REQ_READY = (state == S_IDLE);
  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.RSP_RDATA = rsp_rdata_q;
  assign bus.RSP_ERR   = rsp_err_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed load/store vectors, backpressure,
// mid-transaction reset and a zero-wait instance.
module tb_dmem_responder;

  localparam int WAIT = 2;
`ifdef DMEM_MISALIGN_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  dmem_responder_if bus();
  dmem_responder_if bus0();
  logic [1:0] dbg;
  logic [1:0] dbg0;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(WAIT)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus), .dbg_state(dbg)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .CLK(CLK), .RESET(RESET), .bus(bus0), .dbg_state(dbg0)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic prev_valid = 1'b0;
  logic [32:0] exp_q[$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per response handshake seen on the main bus.
  always @(negedge CLK) begin
    logic [32:0] e;
    if (RESET) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.RSP_VALID && !prev_valid)
        check("latency", 32'(cyc - acc_cyc), 32'(WAIT + 1));
      if (bus.RSP_VALID && bus.RSP_READY) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: got %h expected no response", bus.RSP_RDATA);
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata", bus.RSP_RDATA, e[31:0]);
          check("rsp_err", 32'(bus.RSP_ERR), 32'(e[32]));
        end
      end
      prev_valid = bus.RSP_VALID;
    end
  end

  // Driver: one request on the main bus; track=0 issues without expecting a response.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [32:0] exp, input bit track);
    int n = 0;
    @(negedge CLK);
    while (!bus.REQ_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!bus.REQ_READY) begin
      total++;
      bad++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
      return;
    end
    bus.REQ_VALID = 1'b1;
    bus.REQ_WE    = we;
    bus.REQ_FUNC3 = f3;
    bus.REQ_ADDR  = addr;
    bus.REQ_WDATA = wd;
    @(posedge CLK);
    if (track) exp_q.push_back(exp);
    #1;
    acc_cyc = cyc;
    bus.REQ_VALID = 1'b0;
    // Scramble the held fields; only the values latched at accept may matter.
    bus.REQ_WE    = 1'($urandom_range(0, 1));
    bus.REQ_FUNC3 = 3'($urandom_range(0, 7));
    bus.REQ_ADDR  = $urandom;
    bus.REQ_WDATA = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    @(posedge CLK);
    #1;
  endtask

  task automatic w0_access(input string name, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] exp);
    @(negedge CLK);
    check({name, "_req_ready"}, 32'(bus0.REQ_READY), 32'd1);
    bus0.REQ_VALID = 1'b1;
    bus0.REQ_WE    = we;
    bus0.REQ_FUNC3 = 3'b010;
    bus0.REQ_ADDR  = addr;
    bus0.REQ_WDATA = wd;
    @(posedge CLK);
    #1;
    bus0.REQ_VALID = 1'b0;
    @(negedge CLK);
    check({name, "_valid_early"}, 32'(bus0.RSP_VALID), 32'd0);
    @(negedge CLK);
    check({name, "_valid"}, 32'(bus0.RSP_VALID), 32'd1);
    check({name, "_rdata"}, bus0.RSP_RDATA, exp);
    check({name, "_err"}, 32'(bus0.RSP_ERR), 32'd0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [31:0] held;
    int n;
    bus.REQ_VALID  = 1'b0;
    bus.REQ_WE     = 1'b0;
    bus.REQ_FUNC3  = 3'b000;
    bus.REQ_ADDR   = 32'h0;
    bus.REQ_WDATA  = 32'h0;
    bus.RSP_READY  = 1'b1;
    bus0.REQ_VALID = 1'b0;
    bus0.REQ_WE    = 1'b0;
    bus0.REQ_FUNC3 = 3'b000;
    bus0.REQ_ADDR  = 32'h0;
    bus0.REQ_WDATA = 32'h0;
    bus0.RSP_READY = 1'b1;

    // Clock/reset block
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    check("rst_req_ready", 32'(bus.REQ_READY), 32'd1);
    check("rst_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
    check("rst_rsp_rdata", bus.RSP_RDATA, 32'h0);
    check("rst_rsp_err", 32'(bus.RSP_ERR), 32'd0);
    check("rst_state", 32'(dbg), 32'd0);

    // Word, byte and half accesses
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, {1'b0, 32'h0}, 1'b1);
    issue(1'b0, 3'b010, 32'h10, 32'h0, {1'b0, 32'hDEADBEEF}, 1'b1);
    issue(1'b1, 3'b000, 32'h13, 32'h12345680, {1'b0, 32'h0}, 1'b1);
    issue(1'b0, 3'b000, 32'h13, 32'h0, {1'b0, 32'hFFFFFF80}, 1'b1);
    issue(1'b0, 3'b100, 32'h13, 32'h0, {1'b0, 32'h00000080}, 1'b1);
    issue(1'b0, 3'b010, 32'h10, 32'h0, {1'b0, 32'h80ADBEEF}, 1'b1);
    issue(1'b1, 3'b001, 32'h10, 32'hABCD1234, {1'b0, 32'h0}, 1'b1);
    issue(1'b0, 3'b001, 32'h10, 32'h0, {1'b0, 32'h00001234}, 1'b1);
    issue(1'b0, 3'b010, 32'h10, 32'h0, {1'b0, 32'h80AD1234}, 1'b1);
    issue(1'b0, 3'b101, 32'h12, 32'h0, {1'b0, 32'h000080AD}, 1'b1);
    // Address wraps past the 1024-word array
    issue(1'b0, 3'b010, 32'h1010, 32'h0, {1'b0, 32'h80AD1234}, 1'b1);
    // Undefined store funct3 never writes
    issue(1'b1, 3'b011, 32'h10, 32'hFFFFFFFF, {ERR_EN, 32'h0}, 1'b1);
    issue(1'b0, 3'b010, 32'h10, 32'h0, {1'b0, 32'h80AD1234}, 1'b1);
    // Misaligned word load and undefined load funct3
    issue(1'b0, 3'b010, 32'h11, 32'h0, ERR_EN ? {1'b1, 32'h0} : {1'b0, 32'h80AD1234}, 1'b1);
    issue(1'b0, 3'b011, 32'h10, 32'h0, {ERR_EN, 32'h0}, 1'b1);
    issue(1'b1, 3'b010, 32'h20, 32'h11112222, {1'b0, 32'h0}, 1'b1);
    drain();

    // Backpressure
    bus.RSP_READY = 1'b0;
    issue(1'b0, 3'b010, 32'h10, 32'h0, {1'b0, 32'h80AD1234}, 1'b1);
    n = 0;
    while (!bus.RSP_VALID && n < 20) begin
      @(negedge CLK);
      n++;
    end
    held = bus.RSP_RDATA;
    check("bp_held_rdata", held, 32'h80AD1234);
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 32'(bus.RSP_VALID), 32'd1);
      check("bp_rdata_stable", bus.RSP_RDATA, held);
      check("bp_req_ready", 32'(bus.REQ_READY), 32'd0);
      @(negedge CLK);
    end
    @(posedge CLK);
    #1 bus.RSP_READY = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("bp_req_ready_after", 32'(bus.REQ_READY), 32'd1);
    drain();

    // Reset one cycle after accepting a store: store is abandoned
    issue(1'b1, 3'b010, 32'h20, 32'hCAFEF00D, {1'b0, 32'h0}, 1'b0);
    RESET = 1'b1;
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    check("mid_rst_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
    check("mid_rst_req_ready", 32'(bus.REQ_READY), 32'd1);
    check("mid_rst_state", 32'(dbg), 32'd0);
    issue(1'b0, 3'b010, 32'h20, 32'h0, {1'b0, 32'h11112222}, 1'b1);
    drain();

    // Zero-wait instance
    w0_access("w0_store", 1'b1, 32'h4, 32'h000055AA, 32'h0);
    w0_access("w0_load", 1'b0, 32'h4, 32'h0, 32'h000055AA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
